// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_frame_pkg : state encoding, error codes and defaults for the frame parser
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_CSUM = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/frame_word_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_word_fifo : show-ahead synchronous FIFO with flush, full and empty
// Rev 1.0
// ----------------------------------------------------------------------------
module frame_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the write lands in, so push-while-full is legal with a pop.
  assign do_push = push & (~full | do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_frame_parser : SYNC/CMD/LEN/payload/XOR-checksum parser feeding a word FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN    = 64,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [7:0]  frame_len,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        word_last,
  input  logic        word_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [7:0]    csum;
  logic [7:0]    csum_next;
  logic [7:0]    byte_idx;
  logic [1:0]    lane;
  logic [31:0]   packer;
  logic [31:0]   packed_word;
  logic          last_byte;
  logic          word_done;
  logic          push_q;
  logic [32:0]   push_word;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          ovf;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [32:0]   head;
  logic          cmd_cap;
  logic          len_cap;
  logic          pay_byte;
  logic          ok_set;
  logic          err_set;
  logic [1:0]    err_next;

  assign lane        = byte_idx[1:0];
  assign last_byte   = (byte_idx == frame_len - 8'd1);
  assign word_done   = (lane == 2'd3) | last_byte;
  // Lane 0 starts a fresh word, so upper lanes of a short final word stay zero.
  assign packed_word = ((lane == 2'd0) ? 32'd0 : packer) | ({24'd0, rx_data} << {lane, 3'b000});

  assign pop     = word_ready & ~fifo_empty;
  assign ovf     = push_q & fifo_full & ~pop;
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    csum_next  = csum;
    cmd_cap    = 1'b0;
    len_cap    = 1'b0;
    pay_byte   = 1'b0;
    ok_set     = 1'b0;
    err_set    = 1'b0;
    err_next   = err_code;
    // Overflow comes from the push issued for an earlier byte, so it outranks this cycle's byte.
    if (ovf) begin
      err_set    = 1'b1;
      err_next   = ERR_OVF;
      state_next = IDLE;
    end else if (rx_ready) begin
      case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_next = CMD;
        end
        CMD: begin
          cmd_cap    = 1'b1;
          csum_next  = rx_data;
          state_next = LEN;
        end
        LEN: begin
          len_cap   = 1'b1;
          csum_next = csum ^ rx_data;
          if (rx_data > MAX_LEN_B) begin
            err_set    = 1'b1;
            err_next   = ERR_LEN;
            state_next = IDLE;
          end else if (rx_data == 8'd0) begin
            state_next = CSUM;
          end else begin
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pay_byte  = 1'b1;
          csum_next = csum ^ rx_data;
          if (last_byte) state_next = CSUM;
        end
        CSUM: begin
          if (rx_data == csum) begin
            ok_set = 1'b1;
          end else begin
            err_set  = 1'b1;
            err_next = ERR_CSUM;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (tmo_hit) begin
      err_set    = 1'b1;
      err_next   = ERR_TMO;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd       <= 8'd0;
      cmd_valid <= 1'b0;
      frame_len <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      csum      <= 8'd0;
      byte_idx  <= 8'd0;
      packer    <= 32'd0;
      push_q    <= 1'b0;
      push_word <= 33'd0;
      tmo_cnt   <= '0;
    end else begin
      cmd_valid <= cmd_cap;
      frame_ok  <= ok_set;
      frame_err <= err_set;
      err_code  <= err_next;
      csum      <= csum_next;
      if (cmd_cap) cmd       <= rx_data;
      if (len_cap) frame_len <= rx_data;

      push_q <= pay_byte & word_done;
      if (pay_byte) push_word <= {last_byte, packed_word};

      if (err_set || len_cap) begin
        byte_idx <= 8'd0;
        packer   <= 32'd0;
      end else if (pay_byte) begin
        byte_idx <= byte_idx + 8'd1;
        packer   <= word_done ? 32'd0 : packed_word;
      end

      if (state == IDLE || rx_ready || tmo_hit) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Any abort discards words of the frame, including a push landing in the same cycle.
  frame_word_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (err_set),
    .push      (push_q),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_valid = ~fifo_empty;
  assign word_data  = head[31:0];
  assign word_last  = head[32];

endmodule
`default_nettype wire
